// File: rtl/muldiv_stall_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// muldiv_stall_ctrl_pkg
// Shared definitions for the mul/div stall controller:
//   md_state_e         - 2-bit FSM state encoding (IDLE, DIV_RUN, MUL_RUN, DONE)
//   DEF_DIV_CYCLES     - default number of division iterations
//   DEF_MUL_CYCLES     - default number of multiply iterations
// ---------------------------------------------------------------------------
package muldiv_stall_ctrl_pkg;

    localparam int DEF_DIV_CYCLES = 32;
    localparam int DEF_MUL_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIV_RUN = 2'd1,
        MUL_RUN = 2'd2,
        DONE    = 2'd3
    } md_state_e;

endpackage

// File: rtl/muldiv_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// muldiv_stall_ctrl_if
// Bundle between the pipeline and the mul/div stall controller.
//   Pipeline -> controller : DIV_REQ, MUL_REQ, SIG_BJ, SIG_HAZARDS_D
//   Controller -> pipeline : UNIT_START, STALL_IFID, STALL_IDEX, BUBBLE_EXMEM,
//                            FLUSH_IFID, FLUSH_IDEX, MD_BUSY, MD_DONE
// Modports:
//   master - pipeline side (drives requests, receives stall/flush controls)
//   slave  - controller side
// ---------------------------------------------------------------------------
interface muldiv_stall_ctrl_if;

    logic DIV_REQ;
    logic MUL_REQ;
    logic SIG_BJ;
    logic SIG_HAZARDS_D;
    logic UNIT_START;
    logic STALL_IFID;
    logic STALL_IDEX;
    logic BUBBLE_EXMEM;
    logic FLUSH_IFID;
    logic FLUSH_IDEX;
    logic MD_BUSY;
    logic MD_DONE;

    modport master (
        output DIV_REQ, MUL_REQ, SIG_BJ, SIG_HAZARDS_D,
        input  UNIT_START, STALL_IFID, STALL_IDEX, BUBBLE_EXMEM,
        input  FLUSH_IFID, FLUSH_IDEX, MD_BUSY, MD_DONE
    );

    modport slave (
        input  DIV_REQ, MUL_REQ, SIG_BJ, SIG_HAZARDS_D,
        output UNIT_START, STALL_IFID, STALL_IDEX, BUBBLE_EXMEM,
        output FLUSH_IFID, FLUSH_IDEX, MD_BUSY, MD_DONE
    );

endinterface

// File: rtl/muldiv_stall_ctrl_md_iter_counter.sv
// ---------------------------------------------------------------------------
// md_iter_counter
// Iteration counter for the multi-cycle mul/div unit. Loads a start value,
// decrements by one per enabled cycle and saturates at zero (never wraps).
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (clears count to 0)
//   load       - load load_val (has priority over dec)
//   load_val   - value to load
//   dec        - decrement by one when non-zero
//   zero       - count is zero
// ---------------------------------------------------------------------------
module md_iter_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/muldiv_stall_ctrl.sv
// ---------------------------------------------------------------------------
// muldiv_stall_ctrl
// Pipeline stall/flush controller for a multi-cycle mul/div unit.
// A DIV/MUL request in IDLE pulses UNIT_START and stalls the front of the
// pipeline for DIV_CYCLES+1 / MUL_CYCLES+1 cycles; MD_DONE marks the one
// cycle the result is valid in EX. Branch/jump flushes and load-use
// hazards are merged combinationally with the mul/div stall.
// Ports:
//   CLK    - rising-edge clock
//   RESETN - asynchronous active-low reset
//   bus    - muldiv_stall_ctrl_if.slave (requests in, stall/flush out)
// Build option:
//   MULDIV_FAST_MUL_EN - multiply is single-cycle; MUL_REQ never stalls.
// ---------------------------------------------------------------------------
module muldiv_stall_ctrl
    import muldiv_stall_ctrl_pkg::*;
#(
    parameter int DIV_CYCLES = DEF_DIV_CYCLES,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int CNT_W      = 6
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    muldiv_stall_ctrl_if.slave   bus
);

    md_state_e        state_q, state_d;
    logic             mul_req_eff;
    logic             unit_start;
    logic             md_run;
    logic             md_stall;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

`ifdef MULDIV_FAST_MUL_EN
    // Multiply completes in EX without the iterative unit.
    assign mul_req_eff = 1'b0;
`else
    assign mul_req_eff = bus.MUL_REQ;
`endif

    md_iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk      (CLK),
        .rst_n    (RESETN),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        unit_start   = 1'b0;
        case (state_q)
            IDLE: begin
                // RESETN gates the start pulse so it stays low while reset is held.
                if (RESETN && !bus.SIG_BJ) begin
                    if (bus.DIV_REQ) begin
                        state_d      = DIV_RUN;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(DIV_CYCLES - 1);
                        unit_start   = 1'b1;
                    end else if (mul_req_eff) begin
                        state_d      = MUL_RUN;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(MUL_CYCLES - 1);
                        unit_start   = 1'b1;
                    end
                end
            end
            DIV_RUN, MUL_RUN: begin
                // SIG_BJ here is illegal and deliberately ignored by the FSM.
                if (cnt_zero) begin
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign md_run   = (state_q == DIV_RUN) || (state_q == MUL_RUN);
    assign md_stall = unit_start || md_run;

    always_comb begin
        bus.UNIT_START   = unit_start;
        bus.MD_BUSY      = md_run;
        bus.MD_DONE      = (state_q == DONE);
        bus.STALL_IFID   = md_stall;
        bus.STALL_IDEX   = md_stall;
        bus.BUBBLE_EXMEM = md_stall;
        bus.FLUSH_IFID   = 1'b0;
        bus.FLUSH_IDEX   = 1'b0;
        if (bus.SIG_BJ) begin
            bus.FLUSH_IFID = 1'b1;
            bus.FLUSH_IDEX = 1'b1;
        end else if (bus.SIG_HAZARDS_D && !md_stall) begin
            // Load-use: hold IF/ID and inject a bubble via the ID/EX flush.
            bus.STALL_IFID = 1'b1;
            bus.FLUSH_IDEX = 1'b1;
        end
    end

endmodule

// File: tb/tb_muldiv_stall_ctrl.sv
module tb_muldiv_stall_ctrl;

    localparam int DIV_STALL = 33;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_STALL = 0;
`else
    localparam int MUL_STALL = 5;
`endif

    logic CLK = 1'b0;
    logic RESETN = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   sb_q[$];

    muldiv_stall_ctrl_if bus ();

    muldiv_stall_ctrl dut (
        .CLK    (CLK),
        .RESETN (RESETN),
        .bus    (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs from posedge+1 of the first cycle after the start cycle until
    // MD_DONE (bounded), then scores against the queued expected stall.
    task automatic finish_op(input string tag, input int cnt0, input int inj_j, input int inj_kind);
        int cnt, busy, starts, exp, budget;
        bit got;
        cnt = cnt0; busy = 0; starts = 0; got = 0;
        budget = (sb_q.size() > 0) ? sb_q[0] + 4 : 4;
        for (int j = 1; j <= budget; j++) begin
            if (j == inj_j && inj_kind == 1) bus.SIG_HAZARDS_D = 1'b1;
            if (j == inj_j && inj_kind == 2) bus.SIG_BJ = 1'b1;
            @(negedge CLK);
            if (bus.MD_DONE) begin
                got = 1'b1;
                chk_eq({tag, "_done_stall_ifid"}, int'(bus.STALL_IFID), 0);
                chk_eq({tag, "_done_bubble"}, int'(bus.BUBBLE_EXMEM), 0);
                break;
            end
            cnt    += int'(bus.BUBBLE_EXMEM);
            busy   += int'(bus.MD_BUSY);
            starts += int'(bus.UNIT_START);
            if (j == inj_j && inj_kind == 1) begin
                chk_eq({tag, "_haz_stall_ifid"}, int'(bus.STALL_IFID), 1);
                chk_eq({tag, "_haz_stall_idex"}, int'(bus.STALL_IDEX), 1);
                chk_eq({tag, "_haz_flush_idex"}, int'(bus.FLUSH_IDEX), 0);
            end
            if (j == inj_j && inj_kind == 2) begin
                chk_eq({tag, "_bj_flush_ifid"}, int'(bus.FLUSH_IFID), 1);
                chk_eq({tag, "_bj_flush_idex"}, int'(bus.FLUSH_IDEX), 1);
                chk_eq({tag, "_bj_busy"}, int'(bus.MD_BUSY), 1);
            end
            @(posedge CLK); #1;
            bus.SIG_HAZARDS_D = 1'b0;
            bus.SIG_BJ = 1'b0;
        end
        if (sb_q.size() == 0) begin
            chk_eq({tag, "_sb_empty"}, 1, 0);
        end else begin
            exp = sb_q.pop_front();
            chk_eq({tag, "_stall_cycles"}, cnt, exp);
            chk_eq({tag, "_busy_cycles"}, busy, (exp > 0) ? exp - 1 : 0);
            chk_eq({tag, "_done_seen"}, int'(got), (exp > 0) ? 1 : 0);
            chk_eq({tag, "_extra_start"}, starts, 0);
        end
        if (got) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            chk_eq({tag, "_done_one_cycle"}, int'(bus.MD_DONE), 0);
            chk_eq({tag, "_idle_busy"}, int'(bus.MD_BUSY), 0);
        end
    endtask

    task automatic md_op(input string tag, input logic d, input logic m, input int exp,
                         input int inj_j, input int inj_kind);
        int cnt0;
        sb_q.push_back(exp);
        @(posedge CLK); #1;
        bus.DIV_REQ = d;
        bus.MUL_REQ = m;
        @(negedge CLK);
        chk_eq({tag, "_unit_start"}, int'(bus.UNIT_START), (exp > 0) ? 1 : 0);
        cnt0 = int'(bus.BUBBLE_EXMEM);
        @(posedge CLK); #1;
        bus.DIV_REQ = 1'b0;
        bus.MUL_REQ = 1'b0;
        finish_op(tag, cnt0, inj_j, inj_kind);
    endtask

    initial begin
        int cnt0;
        bus.DIV_REQ = 1'b0;
        bus.MUL_REQ = 1'b0;
        bus.SIG_BJ = 1'b0;
        bus.SIG_HAZARDS_D = 1'b0;

        // reset state
        #12;
        chk_eq("rst_unit_start", int'(bus.UNIT_START), 0);
        chk_eq("rst_busy", int'(bus.MD_BUSY), 0);
        chk_eq("rst_done", int'(bus.MD_DONE), 0);
        chk_eq("rst_stall_ifid", int'(bus.STALL_IFID), 0);
        chk_eq("rst_flush_idex", int'(bus.FLUSH_IDEX), 0);
        @(negedge CLK);
        RESETN = 1'b1;

        md_op("div", 1'b1, 1'b0, DIV_STALL, 0, 0);
        md_op("mul", 1'b0, 1'b1, MUL_STALL, 0, 0);
        md_op("div_and_mul", 1'b1, 1'b1, DIV_STALL, 0, 0);

        // DIV together with branch/jump: flush wins, no start
        @(posedge CLK); #1;
        bus.DIV_REQ = 1'b1;
        bus.SIG_BJ = 1'b1;
        @(negedge CLK);
        chk_eq("bj_div_flush_ifid", int'(bus.FLUSH_IFID), 1);
        chk_eq("bj_div_flush_idex", int'(bus.FLUSH_IDEX), 1);
        chk_eq("bj_div_unit_start", int'(bus.UNIT_START), 0);
        chk_eq("bj_div_stall_ifid", int'(bus.STALL_IFID), 0);
        @(posedge CLK); #1;
        bus.DIV_REQ = 1'b0;
        bus.SIG_BJ = 1'b0;
        @(negedge CLK);
        chk_eq("bj_div_stay_idle", int'(bus.MD_BUSY), 0);

        // load-use hazard in IDLE
        @(posedge CLK); #1;
        bus.SIG_HAZARDS_D = 1'b1;
        @(negedge CLK);
        chk_eq("haz_idle_stall_ifid", int'(bus.STALL_IFID), 1);
        chk_eq("haz_idle_flush_idex", int'(bus.FLUSH_IDEX), 1);
        chk_eq("haz_idle_stall_idex", int'(bus.STALL_IDEX), 0);
        chk_eq("haz_idle_bubble", int'(bus.BUBBLE_EXMEM), 0);
        chk_eq("haz_idle_flush_ifid", int'(bus.FLUSH_IFID), 0);
        @(posedge CLK); #1;
        bus.SIG_HAZARDS_D = 1'b0;
        @(negedge CLK);
        chk_eq("haz_idle_no_start", int'(bus.MD_BUSY), 0);

        // hazard at counter=10 (22nd RUN cycle), illegal BJ in RUN
        md_op("div_haz", 1'b1, 1'b0, DIV_STALL, 22, 1);
        md_op("div_bj", 1'b1, 1'b0, DIV_STALL, 5, 2);

        // reset at counter=15 (17th RUN cycle)
        @(posedge CLK); #1;
        bus.DIV_REQ = 1'b1;
        @(posedge CLK); #1;
        bus.DIV_REQ = 1'b0;
        repeat (16) @(posedge CLK);
        #1;
        chk_eq("pre_rst_busy", int'(bus.MD_BUSY), 1);
        RESETN = 1'b0;
        #1;
        chk_eq("async_rst_busy", int'(bus.MD_BUSY), 0);
        chk_eq("async_rst_done", int'(bus.MD_DONE), 0);
        chk_eq("async_rst_start", int'(bus.UNIT_START), 0);
        chk_eq("async_rst_stall", int'(bus.STALL_IFID), 0);
        bus.DIV_REQ = 1'b1;
        #1;
        chk_eq("rst_held_req_start", int'(bus.UNIT_START), 0);

        // request held across release starts on the first edge
        @(negedge CLK);
        RESETN = 1'b1;
        sb_q.push_back(DIV_STALL);
        #1;
        chk_eq("rereq_unit_start", int'(bus.UNIT_START), 1);
        cnt0 = int'(bus.BUBBLE_EXMEM);
        @(posedge CLK); #1;
        bus.DIV_REQ = 1'b0;
        finish_op("rereq", cnt0, 0, 0);

        md_op("div_after_rst", 1'b1, 1'b0, DIV_STALL, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_stall_ctrl.md
MULDIV_STALL_CTRL -- requirements
Module: muldiv_stall_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: CLK  in  1  rising-edge clock; RESETN  in  1  asynchronous active-low reset.
REQ-002 The block SHALL provide these inputs:
  DIV_REQ  in  1  ID/EX holds DIV/DIVU/REM/REMU.
  MUL_REQ  in  1  ID/EX holds MUL/MULH/MULHSU/MULHU.
  SIG_BJ  in  1  branch/jump taken, resolved in EX.
  SIG_HAZARDS_D  in  1  load-use hazard detected in ID.
REQ-003 The block SHALL provide these outputs:
  UNIT_START  out  1  one-cycle start pulse to the multi-cycle mul/div unit.
  STALL_IFID  out  1  hold IF/ID and PC.
  STALL_IDEX  out  1  hold ID/EX.
  BUBBLE_EXMEM  out  1  load a NOP into EX/MEM.
  FLUSH_IFID  out  1  clear IF/ID.
  FLUSH_IDEX  out  1  clear ID/EX.
  MD_BUSY  out  1  unit running.
  MD_DONE  out  1  result valid in EX this cycle.
REQ-004 The block SHALL use these parameters: DIV_CYCLES, default 32, division iterations; MUL_CYCLES, default 4, multiply iterations; CNT_W, default 6, counter width (at least clog2(DIV_CYCLES+1)).

Function
REQ-005 The FSM SHALL have four states: IDLE, DIV_RUN, MUL_RUN, DONE.
REQ-006 IDLE transitions SHALL be:
  DIV_REQ=1 and SIG_BJ=0: go to DIV_RUN, pulse UNIT_START, load counter with DIV_CYCLES-1.
  MUL_REQ=1 and SIG_BJ=0: go to MUL_RUN in the same way, loading MUL_CYCLES-1.
REQ-007 When DIV_REQ and MUL_REQ are both 1, DIV SHALL win.
REQ-008 In DIV_RUN and MUL_RUN the counter SHALL decrement by 1 per cycle; counter==0 SHALL transition to DONE next cycle, and the counter SHALL never wrap below 0.
REQ-009 DONE SHALL assert MD_DONE for exactly one cycle and then return to IDLE; a new request seen in DONE SHALL NOT start until IDLE.
REQ-010 STALL_IFID, STALL_IDEX and BUBBLE_EXMEM SHALL be 1 during the UNIT_START cycle and in every RUN state; all three SHALL be 0 in DONE.
REQ-011 MD_BUSY SHALL be 1 in the RUN states only.
REQ-012 Total stall from the request cycle SHALL be DIV_CYCLES+1 cycles for DIV and MUL_CYCLES+1 cycles for MUL.
REQ-013 Flush and stall outputs SHALL be combinational and follow this priority:
  SIG_BJ=1: FLUSH_IFID=1 and FLUSH_IDEX=1; mul/div requests are ignored.
  Else SIG_HAZARDS_D=1 with no mul/div stall: STALL_IFID=1, FLUSH_IDEX=1 (bubble), STALL_IDEX=0.
  Else SIG_HAZARDS_D=1 during a mul/div stall: the mul/div stall applies and FLUSH_IDEX=0.
REQ-014 SIG_BJ arriving in a RUN state SHALL be treated as illegal; the FSM SHALL continue unaffected and the flush outputs SHALL still follow SIG_BJ.
REQ-015 UNIT_START SHALL never be asserted outside IDLE.

Reset
REQ-016 RESETN=0 SHALL immediately force IDLE, counter=0, and UNIT_START, MD_BUSY and MD_DONE=0, including mid-operation.
REQ-017 After reset, combinational flush and stall outputs SHALL depend only on the inputs.
REQ-018 A request held across reset release SHALL start on the first rising CLK edge with RESETN=1.

Configuration
REQ-019 With MULDIV_FAST_MUL_EN defined, MUL SHALL be single-cycle: MUL_REQ is ignored by the FSM, MUL_RUN is unreachable, and no stall is generated for MUL.
REQ-020 Without MULDIV_FAST_MUL_EN, MUL SHALL behave per REQ-006 to REQ-012.

Structure
REQ-021 The shared package SHALL hold the FSM state encoding (2-bit: IDLE=0, DIV_RUN=1, MUL_RUN=2, DONE=3) and the defaults DIV_CYCLES and MUL_CYCLES.
REQ-022 The iteration counter SHALL be one sub-module, md_iter_counter: load, decrement and zero-flag, with no wrap.
REQ-023 The FSM and the priority logic SHALL stay in muldiv_stall_ctrl.

Verification
REQ-024 DIV_REQ pulse in IDLE -> UNIT_START 1 cycle; STALL_IFID=1 for 33 cycles; MD_DONE on cycle 34; back to IDLE.
REQ-025 MUL_REQ without the macro -> 5 stall cycles, then MD_DONE. With the macro -> 0 stall cycles and no UNIT_START.
REQ-026 DIV_REQ and SIG_BJ in the same cycle -> FLUSH_IFID=1, FLUSH_IDEX=1, no UNIT_START, FSM stays IDLE.
REQ-027 SIG_HAZARDS_D=1 in IDLE -> STALL_IFID=1, FLUSH_IDEX=1, STALL_IDEX=0. SIG_HAZARDS_D=1 at counter=10 in DIV_RUN -> FLUSH_IDEX=0 and the stall is unchanged.
REQ-028 RESETN low at counter=15 in DIV_RUN -> outputs clear asynchronously and the FSM is IDLE. Re-request after release -> full 33-cycle stall.
REQ-029 DIV_REQ and MUL_REQ both 1 in IDLE -> DIV_RUN entered; the counter loads 31.
